fpu_int_encoder: RTL and testbench

Sequential encoder that converts a signed 32-bit two's-complement integer into the FPU's 32-bit operand format: sign[31], exponent[30:21] (bias 511), mantissa[20:0] with hidden leading 1. It sits in front of the FPU and produces words for `Op_A_in` / `Op_B_in` from integer sources. It uses a valid/ready handshake on both sides, normalizes with a one-bit-per-cycle shift loop, and reports a status code using the FPU's status ordering.

---
 rtl/fpu_int_encoder_if.sv | 20 ++
 rtl/fpu_int_encoder.sv | 95 +++++++++
 tb/tb_fpu_int_encoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fpu_int_encoder_if.sv
// rtl/fpu_int_encoder_if.sv - handshake bundle between an integer source, the encoder and the FPU operand port
interface fpu_int_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] int_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic [1:0]  status_out;

   modport master (
      output in_valid, int_in, out_ready,
      input  in_ready, out_valid, data_out, status_out
   );

   modport slave (
      input  in_valid, int_in, out_ready,
      output in_ready, out_valid, data_out, status_out
   );
endinterface

// File: rtl/fpu_int_encoder.sv
// rtl/fpu_int_encoder.sv - signed int32 to FPU operand word, one-bit-per-cycle normalize loop
// Optional round-to-nearest-even via FPU_ENC_ROUND_NEAREST_EN (default: truncate).
module fpu_int_encoder (
   input  logic              clock_100Khz,
   input  logic              reset,
   fpu_int_encoder_if.slave  bus
);
   localparam logic [1:0] ST_EXACT   = 2'd2;
   localparam logic [1:0] ST_INEXACT = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_NORMALIZE, S_ROUND, S_OUTPUT} state_t;

   state_t      state, state_next;
   logic        sign;
   logic [31:0] mag;
   logic [4:0]  k;
   logic [31:0] data_q;
   logic [1:0]  status_q;

   logic        round_inc;
   logic [21:0] mant_sum;
   logic [9:0]  exp_base;
   logic [9:0]  exp_fin;
   logic        inexact;
   logic [31:0] result;
   logic [1:0]  result_status;

   always_ff @(posedge clock_100Khz or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (bus.in_valid) state_next = S_NORMALIZE;
         S_NORMALIZE: if (mag == 32'd0 || mag[31]) state_next = S_ROUND;
         S_ROUND:     state_next = S_OUTPUT;
         S_OUTPUT:    if (bus.out_ready) state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   // Ties go to even: only bump when guard is set and either sticky or mant LSB is set.
`ifdef FPU_ENC_ROUND_NEAREST_EN
   assign round_inc = mag[9] & ((|mag[8:0]) | mag[10]);
`else
   assign round_inc = 1'b0;
`endif

   always_comb begin
      mant_sum      = {1'b0, mag[30:10]} + {21'd0, round_inc};
      exp_base      = 10'd542 - {5'd0, k};
      exp_fin       = mant_sum[21] ? exp_base + 10'd1 : exp_base;
      inexact       = |mag[9:0];
      result        = {sign, exp_fin, mant_sum[20:0]};
      result_status = inexact ? ST_INEXACT : ST_EXACT;
      if (mag == 32'd0) begin
         result        = 32'h0;
         result_status = ST_EXACT;
      end
   end

   always_ff @(posedge clock_100Khz or negedge reset) begin
      if (!reset) begin
         sign     <= 1'b0;
         mag      <= 32'd0;
         k        <= 5'd0;
         data_q   <= 32'h0;
         status_q <= ST_EXACT;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               sign <= bus.int_in[31];
               mag  <= bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;
               k    <= 5'd0;
            end
            S_NORMALIZE: if (mag != 32'd0 && !mag[31]) begin
               mag <= mag << 1;
               k   <= k + 5'd1;
            end
            S_ROUND: begin
               data_q   <= result;
               status_q <= result_status;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = (state == S_IDLE);
   assign bus.out_valid  = (state == S_OUTPUT);
   assign bus.data_out   = data_q;
   assign bus.status_out = status_q;
endmodule

// File: tb/tb_fpu_int_encoder.sv
// tb/tb_fpu_int_encoder.sv - directed-vector self-checking bench for fpu_int_encoder
`timescale 1ns/1ps
module tb_fpu_int_encoder;
   logic clock_100Khz = 1'b0;
   logic reset        = 1'b0;
   int   n_checks     = 0;
   int   n_fail       = 0;

   fpu_int_encoder_if bus ();

   fpu_int_encoder dut (
      .clock_100Khz (clock_100Khz),
      .reset        (reset),
      .bus          (bus)
   );

   always #5000 clock_100Khz = ~clock_100Khz;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic run_vec(input string tag, input logic [31:0] v, input logic [31:0] exp_d,
                          input logic [1:0] exp_s, input int exp_lat);
      int lat;
      @(negedge clock_100Khz);
      check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      bus.int_in   = v;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clock_100Khz);
      @(negedge clock_100Khz);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clock_100Khz);
         lat++;
         @(negedge clock_100Khz);
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " data"}, bus.data_out, exp_d);
      check({tag, " status"}, {30'd0, bus.status_out}, {30'd0, exp_s});
      bus.out_ready = 1'b1;
      @(posedge clock_100Khz);
      @(negedge clock_100Khz);
      bus.out_ready = 1'b0;
      check({tag, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      int seen;
      logic [31:0] held_d;
      bus.in_valid  = 1'b0;
      bus.int_in    = 32'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clock_100Khz);
      check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset data", bus.data_out, 32'h0);
      check("reset status", {30'd0, bus.status_out}, 32'd2);
      reset = 1'b1;

      run_vec("one",      32'd1,          32'h3FE00000, 2'd2, 33);
      run_vec("minus1",   32'hFFFFFFFF,   32'hBFE00000, 2'd2, 33);
      run_vec("k1000",    32'd1000,       32'h411E8000, 2'd2, 24);
      run_vec("intmin",   32'h80000000,   32'hC3C00000, 2'd2, 2);
      run_vec("zero",     32'd0,          32'h00000000, 2'd2, 2);
`ifdef FPU_ENC_ROUND_NEAREST_EN
      run_vec("intmax",   32'h7FFFFFFF,   32'h43C00000, 2'd3, 3);
      run_vec("tie_odd",  32'h40000300,   32'h43A00002, 2'd3, 3);
`else
      run_vec("intmax",   32'h7FFFFFFF,   32'h43BFFFFF, 2'd3, 3);
      run_vec("tie_odd",  32'h40000300,   32'h43A00001, 2'd3, 3);
`endif
      run_vec("tie_even", 32'h40000100,   32'h43A00000, 2'd3, 3);

      // Handshake: busy-time input is ignored and a stalled result holds steady.
      @(negedge clock_100Khz);
      bus.int_in = 32'd1000;
      bus.in_valid = 1'b1;
      @(negedge clock_100Khz);
      for (int i = 0; i < 30; i++) begin
         bus.in_valid = i[0];
         bus.int_in   = 32'h12345678 + i;
         @(negedge clock_100Khz);
         if (bus.out_valid) break;
      end
      bus.in_valid = 1'b0;
      check("hs out_valid", {31'd0, bus.out_valid}, 32'd1);
      held_d = 32'h411E8000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock_100Khz);
         check("hs hold data", bus.data_out, held_d);
         check("hs hold in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      check("hs hold valid", {31'd0, bus.out_valid}, 32'd1);
      bus.out_ready = 1'b1;
      @(negedge clock_100Khz);
      bus.out_ready = 1'b0;
      check("hs release valid", {31'd0, bus.out_valid}, 32'd0);
      check("hs release in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Reset in the middle of a long conversion.
      bus.int_in = 32'd1;
      bus.in_valid = 1'b1;
      @(negedge clock_100Khz);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clock_100Khz);
      reset = 1'b0;
      #1;
      check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst data", bus.data_out, 32'h0);
      check("midrst status", {30'd0, bus.status_out}, 32'd2);
      check("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clock_100Khz);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock_100Khz);
         if (bus.out_valid) seen++;
      end
      check("midrst no result", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
